// File: rtl/text_console_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// text_console_ctrl : ASCII stream to 80x30 tile RAM writer, cursor and scroll
// Rev 1.0
// ----------------------------------------------------------------------------
module text_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic [4:0]  row_offset,
  output logic        busy
);

  localparam logic [11:0] CELLS    = 12'(COLS * ROWS);
  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [7:0]  CODE_BS  = 8'h08;
  localparam logic [7:0]  CODE_LF  = 8'h0A;
  localparam logic [7:0]  CODE_FF  = 8'h0C;
  localparam logic [7:0]  CODE_CR  = 8'h0D;

  typedef enum logic [1:0] {
    S_CLEAR_ALL = 2'd0,
    S_IDLE      = 2'd1,
    S_PUT       = 2'd2,
    S_CLEAR_ROW = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;
  logic [7:0]  code, code_n;
  logic [6:0]  cursor_col_n;
  logic [4:0]  cursor_row_n;
  logic [4:0]  row_offset_n;
  logic        wr_en_n;
  logic [11:0] wr_addr_n;
  logic [7:0]  wr_data_n;
  logic        char_ready_n;
  logic        busy_n;
  logic        newline;
  logic        accept;

  // Logical row to tile address, wrapping the row by compare-and-subtract.
  function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [4:0] off,
                                            input logic [6:0] c);
    logic [5:0] sum;
    sum = {1'b0, r} + {1'b0, off};
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    return 12'(sum[4:0]) * COLS_W + 12'(c);
  endfunction

  assign accept = char_valid && char_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_CLEAR_ALL;
      cnt        <= 12'd0;
      code       <= 8'd0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
      row_offset <= 5'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 12'd0;
      wr_data    <= BLANK;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      code       <= code_n;
      cursor_col <= cursor_col_n;
      cursor_row <= cursor_row_n;
      row_offset <= row_offset_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      char_ready <= char_ready_n;
      busy       <= busy_n;
    end
  end

  // Registered outputs are computed for the state being entered.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    code_n       = code;
    cursor_col_n = cursor_col;
    cursor_row_n = cursor_row;
    row_offset_n = row_offset;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    char_ready_n = 1'b0;
    busy_n       = busy;
    newline      = 1'b0;

    case (state)
      S_CLEAR_ALL: begin
        if (cnt == CELLS) begin
          state_n      = S_IDLE;
          cursor_col_n = 7'd0;
          cursor_row_n = 5'd0;
          row_offset_n = 5'd0;
          busy_n       = 1'b0;
          char_ready_n = 1'b1;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = cnt;
          wr_data_n = BLANK;
          cnt_n     = cnt + 12'd1;
        end
      end

      S_IDLE: begin
        char_ready_n = 1'b1;
        if (accept) begin
          code_n       = char_in;
          char_ready_n = 1'b0;
          if (char_in == CODE_FF) begin
            state_n = S_CLEAR_ALL;
            cnt_n   = 12'd0;
            busy_n  = 1'b1;
          end else begin
            state_n = S_PUT;
            case (char_in)
              CODE_BS: begin
                if (cursor_col != 7'd0) begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = cell_addr(cursor_row, row_offset, cursor_col - 7'd1);
                  wr_data_n = BLANK;
                end
              end
              CODE_CR, CODE_LF: ;
              default: begin
                wr_en_n   = 1'b1;
                wr_addr_n = cell_addr(cursor_row, row_offset, cursor_col);
                wr_data_n = char_in;
              end
            endcase
          end
        end
      end

      S_PUT: begin
        state_n      = S_IDLE;
        char_ready_n = 1'b1;
        case (code)
          CODE_BS: begin
            if (cursor_col != 7'd0) cursor_col_n = cursor_col - 7'd1;
          end
          CODE_CR: cursor_col_n = 7'd0;
          CODE_LF: begin
            cursor_col_n = 7'd0;
            newline      = 1'b1;
          end
          default: begin
            if (cursor_col == LAST_COL) begin
              cursor_col_n = 7'd0;
              newline      = 1'b1;
            end else begin
              cursor_col_n = cursor_col + 7'd1;
            end
          end
        endcase
        if (newline) begin
          if (cursor_row < LAST_ROW) begin
            cursor_row_n = cursor_row + 5'd1;
          end else begin
            // The old top physical row becomes the new bottom row and is blanked.
            row_offset_n = (row_offset == LAST_ROW) ? 5'd0 : row_offset + 5'd1;
            state_n      = S_CLEAR_ROW;
            char_ready_n = 1'b0;
            busy_n       = 1'b1;
            wr_en_n      = 1'b1;
            wr_addr_n    = 12'(row_offset) * COLS_W;
            wr_data_n    = BLANK;
            cnt_n        = 12'd1;
          end
        end
      end

      S_CLEAR_ROW: begin
        if (cnt == COLS_W) begin
          state_n      = S_IDLE;
          busy_n       = 1'b0;
          char_ready_n = 1'b1;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = wr_addr + 12'd1;
          wr_data_n = BLANK;
          cnt_n     = cnt + 12'd1;
        end
      end

      default: state_n = S_CLEAR_ALL;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_text_console_ctrl : table vectors plus write scoreboard for text_console_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_text_console_ctrl;

  localparam int         COLS  = 80;
  localparam int         ROWS  = 30;
  localparam logic [7:0] BLANK = 8'h20;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  row_offset;
  logic        busy;

  text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
    .Clk(Clk), .Reset(Reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .row_offset(row_offset), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int printed = 0;
  logic [19:0] exp_q[$];
  bit mon_on = 1'b0;

  int m_col = 0, m_row = 0, m_off = 0;
  int cyc, nwr, nbusy, first_wr, last_wr;
  bit last_exp_wr;

  typedef struct {
    logic [7:0] ch;
    int         col;
    int         row;
    int         off;
    bit         wr;
    int         cyc;
  } vec_t;
  vec_t vecs[12];

  task automatic note_fail(input string msg);
    fails++;
    if (printed < 40) begin
      $display("FAIL %s", msg);
      printed++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) note_fail($sformatf("%s: got %0d required %0d", name, act, exp));
  endtask

  always @(negedge Clk) begin
    if (mon_on && wr_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        note_fail($sformatf("sb_unexpected: addr=%0d data=%h, required no write", wr_addr, wr_data));
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e)
          note_fail($sformatf("sb_write: addr=%0d data=%h required addr=%0d data=%h",
                              wr_addr, wr_data, e[19:8], e[7:0]));
      end
    end
  end

  task automatic push_clear_all();
    for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back({12'(i), BLANK});
  endtask

  task automatic model_newline();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int i = 0; i < COLS; i++) exp_q.push_back({12'(m_off * COLS + i), BLANK});
      m_off = (m_off + 1) % ROWS;
    end
  endtask

  task automatic model_char(input logic [7:0] ch, output bit w);
    w = 1'b0;
    case (ch)
      8'h0C: begin
        push_clear_all();
        m_col = 0; m_row = 0; m_off = 0;
      end
      8'h0D: m_col = 0;
      8'h0A: begin
        m_col = 0;
        model_newline();
      end
      8'h08: begin
        if (m_col > 0) begin
          m_col--;
          exp_q.push_back({12'(((m_row + m_off) % ROWS) * COLS + m_col), BLANK});
          w = 1'b1;
        end
      end
      default: begin
        exp_q.push_back({12'(((m_row + m_off) % ROWS) * COLS + m_col), ch});
        w = 1'b1;
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          model_newline();
        end
      end
    endcase
  endtask

  task automatic run_until_ready(input int budget);
    cyc = 0; nwr = 0; nbusy = 0; first_wr = -1; last_wr = -1;
    do begin
      @(posedge Clk); #2;
      cyc++;
      if (busy) nbusy++;
      if (wr_en) begin
        nwr++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
    end while (!char_ready && cyc < budget);
    tests++;
    if (char_ready !== 1'b1) note_fail($sformatf("ready_timeout: char_ready=%0b after %0d cycles, required 1", char_ready, cyc));
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < 3000) begin
      @(posedge Clk); #2;
      n++;
    end
    tests++;
    if (char_ready !== 1'b1) note_fail($sformatf("ready_wait: char_ready=%0b required 1", char_ready));
    model_char(ch, last_exp_wr);
    char_in = ch;
    char_valid = 1'b1;
    @(posedge Clk); #2;
    char_valid = 1'b0;
    char_in = 8'($urandom);
    check($sformatf("put_wr_en ch=%h", ch), 32'(wr_en), 32'(last_exp_wr));
    run_until_ready(3000);
  endtask

  task automatic check_cursor(input string name);
    check({name, "_col"}, 32'(cursor_col), 32'(m_col));
    check({name, "_row"}, 32'(cursor_row), 32'(m_row));
    check({name, "_off"}, 32'(row_offset), 32'(m_off));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_sum;
    vecs[0]  = '{8'h41, 1, 0, 0, 1'b1, 1};
    vecs[1]  = '{8'h0D, 0, 0, 0, 1'b0, 1};
    vecs[2]  = '{8'h08, 0, 0, 0, 1'b0, 1};
    vecs[3]  = '{8'h0A, 0, 1, 0, 1'b0, 1};
    vecs[4]  = '{8'h0A, 0, 2, 0, 1'b0, 1};
    vecs[5]  = '{8'h61, 1, 2, 0, 1'b1, 1};
    vecs[6]  = '{8'h62, 2, 2, 0, 1'b1, 1};
    vecs[7]  = '{8'h63, 3, 2, 0, 1'b1, 1};
    vecs[8]  = '{8'h64, 4, 2, 0, 1'b1, 1};
    vecs[9]  = '{8'h65, 5, 2, 0, 1'b1, 1};
    vecs[10] = '{8'h08, 4, 2, 0, 1'b1, 1};
    vecs[11] = '{8'h0D, 0, 2, 0, 1'b0, 1};

    // Reset values, then the power-up sweep.
    @(posedge Clk); #2;
    check("rst_col", 32'(cursor_col), 0);
    check("rst_row", 32'(cursor_row), 0);
    check("rst_off", 32'(row_offset), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 32'(BLANK));
    check("rst_ready", 32'(char_ready), 0);
    check("rst_busy", 32'(busy), 1);
    push_clear_all();
    mon_on = 1'b1;
    Reset = 1'b0;
    run_until_ready(3000);
    check("clr_writes", nwr, 2400);
    check("clr_span", last_wr - first_wr + 1, 2400);
    check("clr_busy", nbusy, 2400);
    check("clr_cycles", cyc, 2401);
    check("clr_q_empty", exp_q.size(), 0);
    check_cursor("clr");

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].ch);
      check($sformatf("vec%0d_wr", i), 32'(last_exp_wr), 32'(vecs[i].wr));
      check($sformatf("vec%0d_col", i), 32'(cursor_col), vecs[i].col);
      check($sformatf("vec%0d_row", i), 32'(cursor_row), vecs[i].row);
      check($sformatf("vec%0d_off", i), 32'(row_offset), vecs[i].off);
      check($sformatf("vec%0d_cyc", i), cyc, vecs[i].cyc);
    end
    check("vec_q_empty", exp_q.size(), 0);

    send(8'h0C);
    check("ff_cycles", cyc, 2401);
    check_cursor("ff");

    busy_sum = 0;
    for (int i = 0; i < COLS; i++) begin
      send(8'h42);
      busy_sum += nbusy;
    end
    check("row0_busy", busy_sum, 0);
    check("row0_col", 32'(cursor_col), 0);
    check("row0_row", 32'(cursor_row), 1);

    for (int i = 0; i < 28; i++) send(8'h0A);
    check_cursor("row29");

    send(8'h0A);
    check("scroll_off", 32'(row_offset), 1);
    check("scroll_row", 32'(cursor_row), 29);
    check("scroll_col", 32'(cursor_col), 0);
    check("scroll_busy", nbusy, 80);
    check("scroll_writes", nwr, 80);
    check("scroll_cycles", cyc, 81);

    send(8'h43);
    check("after_scroll_col", 32'(cursor_col), 1);

    for (int i = 0; i < COLS - 1; i++) send(8'h44);
    check("wrap_scroll_busy", nbusy, 80);
    check_cursor("wrap_scroll");

    send(8'h08);
    check("bs0_wr", 32'(last_exp_wr), 0);
    check_cursor("bs0");

    for (int i = 0; i < 28; i++) send(8'h0A);
    check("off_wrap", 32'(row_offset), 0);
    check_cursor("off_wrap");

    send(8'h0A);
    check("pre_ff_off", 32'(row_offset), 1);
    send(8'h0C);
    check_cursor("ff2");
    check("ff2_q_empty", exp_q.size(), 0);

    // Reset in the middle of a full clear restarts the sweep.
    Reset = 1'b1;
    mon_on = 1'b0;
    @(posedge Clk); #2;
    push_clear_all();
    m_col = 0; m_row = 0; m_off = 0;
    mon_on = 1'b1;
    Reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge Clk); #2;
    end
    check("mid_wr_en", 32'(wr_en), 1);
    check("mid_wr_addr", 32'(wr_addr), 999);
    Reset = 1'b1;
    mon_on = 1'b0;
    @(posedge Clk); #2;
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_addr", 32'(wr_addr), 0);
    check("mid_rst_busy", 32'(busy), 1);
    exp_q.delete();
    push_clear_all();
    mon_on = 1'b1;
    Reset = 1'b0;
    run_until_ready(3000);
    check("reclr_writes", nwr, 2400);
    check("reclr_span", last_wr - first_wr + 1, 2400);
    check("reclr_q_empty", exp_q.size(), 0);
    check_cursor("reclr");

    send(8'h41);
    check("final_col", 32'(cursor_col), 1);
    @(posedge Clk); #2;
    check("final_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
Character-stream controller for the 80x30 text-mode tile RAM. It accepts ASCII codes over a valid/ready handshake and maintains a cursor. It issues one-port writes to the tile RAM and handles control codes. It scrolls by rotating a row offset that the display path adds to its physical row index, so the screen is never copied in memory.

Parameters:
COLS, 80, columns per screen (tiles per row)
ROWS, 30, rows per screen
BLANK, 8'h20, code written when clearing cells

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
char_in  input  8  character/control code
char_valid  input  1  char_in is valid
char_ready  output  1  controller accepts char_in this cycle
wr_en  output  1  tile RAM write strobe
wr_addr  output  12  tile RAM address = phys_row*COLS + col (0..2399)
wr_data  output  8  tile code to write
cursor_col  output  7  logical cursor column (0..COLS-1)
cursor_row  output  5  logical cursor row (0..ROWS-1)
row_offset  output  5  physical row of logical row 0 (0..ROWS-1); display uses phys = (logical + row_offset) mod ROWS
busy  output  1  high in CLEAR_ALL or CLEAR_ROW

Behaviour:
- Clock and reset: one clock, Clk; Reset is synchronous and active-high. All outputs are registered.
- Reset values: cursor_col=0, cursor_row=0, row_offset=0, wr_en=0, wr_addr=0, wr_data=BLANK, char_ready=0, busy=1. State goes to CLEAR_ALL.
- Reset asserted in any state, including mid-clear, restarts CLEAR_ALL from address 0.
- Physical row: phys(r) = (r + row_offset) mod ROWS. Compute it by compare-and-subtract; do not use a divider.
- Handshake:
  - A character is accepted on a rising edge where char_valid && char_ready.
  - char_ready=1 only in IDLE.
  - char_in is sampled only at acceptance. The controller holds nothing from the source afterwards.
- States:
  - CLEAR_ALL:
    - Writes BLANK to addresses 0..COLS*ROWS-1, one per cycle, wr_en=1 each cycle. That is 2400 writes.
    - Then cursor=(0,0), row_offset=0, busy=0, go to IDLE.
  - IDLE:
    - wr_en=0, char_ready=1.
    - On acceptance, decode char_in and go to PUT, or to CLEAR_ALL for 0x0C.
  - PUT (exactly one cycle), by code:
    - Printable (any code other than 0x08, 0x0A, 0x0C, 0x0D):
      - wr_en=1, wr_addr=phys(cursor_row)*COLS+cursor_col, wr_data=char_in.
      - Then cursor_col++.
      - If cursor_col was COLS-1: set cursor_col=0 and perform NEWLINE.
    - 0x0D (CR): cursor_col=0, no write.
    - 0x0A (LF): cursor_col=0, then NEWLINE, no write.
    - 0x08 (BS):
      - If cursor_col>0: cursor_col--, then write BLANK at the new position (wr_en=1 in PUT).
      - If cursor_col==0: no write, cursor unchanged. There is no wrap to the previous row.
  - NEWLINE (evaluated inside PUT):
    - If cursor_row<ROWS-1: cursor_row++ and return to IDLE.
    - Else: cursor_row stays ROWS-1, row_offset=(row_offset+1) mod ROWS, go to CLEAR_ROW.
  - CLEAR_ROW:
    - Writes BLANK to the COLS cells of physical row phys_new(ROWS-1), which equals the old row_offset.
    - Addresses ascending, one per cycle, COLS cycles, busy=1.
    - Then go to IDLE.
- Latency and throughput:
  - Write occurs in the cycle after acceptance.
  - Minimum spacing is 2 cycles per accepted character.
  - A scroll adds COLS cycles.
- Timing of cursor/row_offset updates: they take their new values on the same edge that ends PUT.
- wr_en is never asserted outside CLEAR_ALL, PUT and CLEAR_ROW.

Test Plan:
- Reset held 1 cycle, then released → exactly 2400 consecutive wr_en pulses, addr 0..2399, data 0x20. char_ready=0 throughout, then 1; cursor (0,0).
- Send 0x41 at home → one write addr 0 data 0x41 the cycle after acceptance; cursor_col=1.
- Send 80 × 0x42 from home → addrs 0..79; cursor becomes (col 0, row 1); no CLEAR_ROW.
- Fill to row 29 and send LF → row_offset 0→1, cursor (0,29), 80 writes of 0x20 to addr 0..79, busy high 80 cycles. A following 0x43 writes addr 0.
- BS at col 0 → no wr_en, cursor unchanged. BS at col 5, row 2 (offset 0) → write 0x20 at addr 164, cursor_col=4.
- Assert Reset at cycle 1000 of CLEAR_ALL → sweep restarts at addr 0 and completes all 2400 writes. Sending 0x0C from IDLE repeats the full clear and resets row_offset to 0.
